spike_aer_encoder: RTL and testbench

- Downstream consumer of config memory read port B; sits between the neuron update controller and the NoC router injection port.
- On each neuron fire event it looks up that neuron's SpikeAER destination word through config port B and queues the packet in a small FIFO.
- It then presents the packets to the router with a valid/ready handshake.
- It is the only master of config port B address/enable while it is instantiated.

---
 rtl/spike_aer_encoder_pkg.sv | 19 +
 rtl/aer_fwft_fifo.sv | 61 ++++++
 rtl/spike_aer_encoder.sv | 134 +++++++++++++
 tb/tb_spike_aer_encoder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_aer_encoder_pkg.sv
// Shared types and helpers for the spike AER encoder: FSM state encoding,
// default packet width and the FIFO pointer-width function.
package spike_aer_encoder_pkg;

  localparam int AER_BIT_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    PUSH = 2'd3
  } aerState_t;

  // Pointer width for a power-of-two queue; never narrower than one bit.
  function automatic int ptrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/aer_fwft_fifo.sv
// First-word-fall-through circular queue for outgoing AER packets.
// head_data is forced to zero while the queue is empty.
module aer_fwft_fifo
  import spike_aer_encoder_pkg::*;
#(
  parameter int DATA_WIDTH = AER_BIT_WIDTH_DEF,
  parameter int DEPTH      = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        push,
  input  logic [DATA_WIDTH-1:0]       push_data,
  input  logic                        pop,
  output logic [DATA_WIDTH-1:0]       head_data,
  output logic [ptrWidth(DEPTH):0]    count
);

  localparam int PW = ptrWidth(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wrPtr;
  logic [PW-1:0]         rdPtr;
  logic [PW:0]           countReg;
  logic                  doPop;
  logic                  doPush;

  assign doPop  = pop && (countReg != '0);
  // A push into a full queue is only taken when the head leaves in the same cycle.
  assign doPush = push && ((countReg != FULL_CNT) || doPop);

  always_ff @(posedge clk_i) begin
    if (doPush) begin
      mem[wrPtr] <= push_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      countReg <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + PW'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + PW'(1);
      end
      case ({doPush, doPop})
        2'b10:   countReg <= countReg + (PW + 1)'(1);
        2'b01:   countReg <= countReg - (PW + 1)'(1);
        default: countReg <= countReg;
      endcase
    end
  end

  assign head_data = (countReg != '0) ? mem[rdPtr] : '0;
  assign count     = countReg;

endmodule

// File: rtl/spike_aer_encoder.sv
// Turns neuron fire events into AER packets via a config-port-B lookup and queues them for the router.
// Optional build macro SPIKE_TIMESTAMP_EN replaces the low packet bits with a tick counter.
module spike_aer_encoder
  import spike_aer_encoder_pkg::*;
#(
  parameter int NURN_CNT_BIT_WIDTH = 8,
  parameter int AER_BIT_WIDTH      = AER_BIT_WIDTH_DEF,
  parameter int FIFO_DEPTH         = 4,
  parameter int CFG_RD_LAT         = 2,
  parameter int TS_BIT_WIDTH       = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic                              fire_valid_i,
  input  logic [NURN_CNT_BIT_WIDTH-1:0]     fire_nurn_i,
  output logic                              fire_ready_o,
  input  logic                              tick_i,
  output logic [NURN_CNT_BIT_WIDTH-1:0]     Addr_Config_B_o,
  output logic                              rdEn_Config_B_o,
  input  logic [AER_BIT_WIDTH-1:0]          SpikeAER_i,
  output logic                              aer_valid_o,
  output logic [AER_BIT_WIDTH-1:0]          aer_data_o,
  input  logic                              aer_ready_i,
  output logic [ptrWidth(FIFO_DEPTH):0]     fifo_cnt_o
);

  localparam int PW = ptrWidth(FIFO_DEPTH);
  localparam logic [PW:0] FIFO_FULL = (PW + 1)'(FIFO_DEPTH);
  localparam logic [2:0]  LAT_LOAD  = 3'(CFG_RD_LAT - 1);

  aerState_t                     stateReg;
  aerState_t                     stateNext;
  logic [2:0]                    latCntReg;
  logic [2:0]                    latCntNext;
  logic [NURN_CNT_BIT_WIDTH-1:0] addrReg;
  logic [NURN_CNT_BIT_WIDTH-1:0] addrNext;
  logic [AER_BIT_WIDTH-1:0]      captureReg;
  logic [AER_BIT_WIDTH-1:0]      captureNext;
  logic [AER_BIT_WIDTH-1:0]      packetWord;
  logic                          fireReady;
  logic                          pushEn;

`ifdef SPIKE_TIMESTAMP_EN
  logic [TS_BIT_WIDTH-1:0] tsReg;
  logic [TS_BIT_WIDTH-1:0] unusedAerLow;

  // Capture samples tsReg before this edge's increment, so a coincident tick is not seen.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tsReg <= '0;
    end else if (tick_i) begin
      tsReg <= tsReg + TS_BIT_WIDTH'(1);
    end
  end

  assign packetWord   = {SpikeAER_i[AER_BIT_WIDTH-1:TS_BIT_WIDTH], tsReg};
  assign unusedAerLow = SpikeAER_i[TS_BIT_WIDTH-1:0];
`else
  localparam int unusedTsWidth = TS_BIT_WIDTH;
  logic unusedTick;

  assign packetWord = SpikeAER_i;
  assign unusedTick = tick_i;
`endif

  // Ready is held low during reset even though the state already reads IDLE.
  assign fireReady = rst_n_i && (stateReg == IDLE) && (fifo_cnt_o < FIFO_FULL);

  always_comb begin
    stateNext   = stateReg;
    latCntNext  = latCntReg;
    addrNext    = addrReg;
    captureNext = captureReg;
    pushEn      = 1'b0;
    case (stateReg)
      IDLE: begin
        if (fire_valid_i && fireReady) begin
          addrNext  = fire_nurn_i;
          stateNext = REQ;
        end
      end
      REQ: begin
        latCntNext = LAT_LOAD;
        stateNext  = WAIT;
      end
      WAIT: begin
        if (latCntReg == 3'd0) begin
          captureNext = packetWord;
          stateNext   = PUSH;
        end else begin
          latCntNext = latCntReg - 3'd1;
        end
      end
      PUSH: begin
        pushEn    = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stateReg   <= IDLE;
      latCntReg  <= '0;
      addrReg    <= '0;
      captureReg <= '0;
    end else begin
      stateReg   <= stateNext;
      latCntReg  <= latCntNext;
      addrReg    <= addrNext;
      captureReg <= captureNext;
    end
  end

  aer_fwft_fifo #(
    .DATA_WIDTH (AER_BIT_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) uFifo (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .push      (pushEn),
    .push_data (captureReg),
    .pop       (aer_valid_o && aer_ready_i),
    .head_data (aer_data_o),
    .count     (fifo_cnt_o)
  );

  assign aer_valid_o     = (fifo_cnt_o != '0);
  assign fire_ready_o    = fireReady;
  assign rdEn_Config_B_o = (stateReg == REQ);
  assign Addr_Config_B_o = addrReg;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Directed bench for spike_aer_encoder: a queue-level model checked every cycle,
// plus hand-computed literal expectations for latency, ordering and reset.
module tb_spike_aer_encoder;

  localparam int NW    = 8;
  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;
  localparam int TSW   = 8;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          fire_valid_i = 1'b0;
  logic [NW-1:0] fire_nurn_i = '0;
  logic          tick_i = 1'b0;
  logic          aer_ready_i = 1'b0;
  logic [AW-1:0] SpikeAER_i;
  logic          fire_ready_o;
  logic [NW-1:0] Addr_Config_B_o;
  logic          rdEn_Config_B_o;
  logic          aer_valid_o;
  logic [AW-1:0] aer_data_o;
  logic [2:0]    fifo_cnt_o;

  int vecCnt = 0;
  int errCnt = 0;

  spike_aer_encoder #(
    .NURN_CNT_BIT_WIDTH (NW),
    .AER_BIT_WIDTH      (AW),
    .FIFO_DEPTH         (DEPTH),
    .CFG_RD_LAT         (LAT),
    .TS_BIT_WIDTH       (TSW)
  ) dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .fire_valid_i    (fire_valid_i),
    .fire_nurn_i     (fire_nurn_i),
    .fire_ready_o    (fire_ready_o),
    .tick_i          (tick_i),
    .Addr_Config_B_o (Addr_Config_B_o),
    .rdEn_Config_B_o (rdEn_Config_B_o),
    .SpikeAER_i      (SpikeAER_i),
    .aer_valid_o     (aer_valid_o),
    .aer_data_o      (aer_data_o),
    .aer_ready_i     (aer_ready_i),
    .fifo_cnt_o      (fifo_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] memWord(input logic [7:0] idx);
    if (idx == 8'hFF) return 32'hFFFF_FFFF;
    return 32'hA5A5_0100 | {24'h0, idx};
  endfunction

  // Packet expected when no tick has occurred since reset.
  function automatic logic [31:0] expWord(input logic [7:0] idx);
    logic [31:0] w;
    w = memWord(idx);
`ifdef SPIKE_TIMESTAMP_EN
    w[7:0] = 8'h00;
`endif
    return w;
  endfunction

  // Config memory port B: fixed read latency, junk when no read is in flight.
  logic [AW-1:0] cfgPipe [LAT];
  always @(posedge clk_i) begin
    cfgPipe[0] <= rdEn_Config_B_o ? memWord(Addr_Config_B_o) : 32'hDEAD_BEEF;
    for (int k = 1; k < LAT; k++) cfgPipe[k] <= cfgPipe[k-1];
  end
  assign SpikeAER_i = cfgPipe[LAT-1];

  // Transaction-level model: one lookup in flight, lands LAT+2 edges after accept.
  logic [31:0] modelQ[$];
  int          edgeN = 0;
  int          acceptEdge = -1;
  int          landEdge = -1;
  int          nextFree = 0;
  bit          pendValid = 0;
  logic [31:0] pendPkt = '0;
  logic [7:0]  lastAddr = '0;
  logic [7:0]  modelTs = '0;

  initial forever begin
    bit rdy;
    @(posedge clk_i);
    edgeN++;
    if (!rst_n_i) begin
      modelQ.delete();
      pendValid  = 0;
      nextFree   = 0;
      acceptEdge = -1;
      lastAddr   = '0;
      modelTs    = '0;
    end else begin
      rdy = (edgeN >= nextFree) && (modelQ.size() < DEPTH);
      if (modelQ.size() > 0 && aer_ready_i) void'(modelQ.pop_front());
`ifdef SPIKE_TIMESTAMP_EN
      if (pendValid && edgeN == acceptEdge + LAT + 1) pendPkt[7:0] = modelTs;
      if (tick_i) modelTs = modelTs + 8'd1;
`endif
      if (pendValid && edgeN == landEdge) begin
        modelQ.push_back(pendPkt);
        pendValid = 0;
      end
      if (fire_valid_i && rdy) begin
        acceptEdge = edgeN;
        landEdge   = edgeN + LAT + 2;
        nextFree   = edgeN + LAT + 3;
        pendPkt    = memWord(fire_nurn_i);
        lastAddr   = fire_nurn_i;
        pendValid  = 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vecCnt++;
    if (got !== want) begin
      errCnt++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  logic [31:0] popLog[$];
  int          maxCnt = 0;

  task automatic fireOne(input logic [7:0] idx, output time accT);
    bit r;
    bit done;
    done = 0;
    accT = 0;
    fire_valid_i = 1'b1;
    fire_nurn_i  = idx;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk_i);
      r = fire_ready_o;
      @(posedge clk_i);
      if (r) begin
        done = 1;
        accT = $time;
      end
    end
    #2 fire_valid_i = 1'b0;
    check($sformatf("fire_accept_%0d", idx), {31'b0, done}, 32'd1);
    $display("fire idx=%0d accepted=%0b t=%0t", idx, done, accT);
  endtask

  task automatic checkAllZero(input string name);
    check({name, "_ctl"}, {18'b0, aer_valid_o, fifo_cnt_o, fire_ready_o, rdEn_Config_B_o,
                            Addr_Config_B_o}, 32'd0);
    check({name, "_data"}, aer_data_o, 32'd0);
  endtask

  initial begin
    fork
      forever begin
        logic [31:0] wantCtl;
        bit          expValid;
        bit          expReady;
        @(negedge clk_i);
        if (!rst_n_i) begin
          checkAllZero($sformatf("cyc%0d_rst", edgeN));
        end else begin
          expValid = modelQ.size() != 0;
          expReady = (edgeN + 1 >= nextFree) && (modelQ.size() < DEPTH);
          wantCtl  = {18'b0, expValid, 3'(modelQ.size()), expReady, edgeN == acceptEdge, lastAddr};
          check($sformatf("cyc%0d_ctl", edgeN),
                {18'b0, aer_valid_o, fifo_cnt_o, fire_ready_o, rdEn_Config_B_o, Addr_Config_B_o},
                wantCtl);
          if (expValid) check($sformatf("cyc%0d_data", edgeN), aer_data_o, modelQ[0]);
          if (aer_valid_o && aer_ready_i) popLog.push_back(aer_data_o);
          if (int'(fifo_cnt_o) > maxCnt) maxCnt = int'(fifo_cnt_o);
        end
      end
      begin
        time t;
        time accT [6];
        repeat (3) @(posedge clk_i);
        #2 checkAllZero("reset");
        rst_n_i = 1'b1;

        // Single lookup latency.
        fireOne(8'h05, t);
        check("t1_rden", {31'b0, rdEn_Config_B_o}, 32'd1);
        check("t1_addr", {24'b0, Addr_Config_B_o}, 32'd5);
        repeat (3) @(posedge clk_i);
        #2 check("t1_valid_T4", {31'b0, aer_valid_o}, 32'd0);
        @(posedge clk_i);
        #2 check("t1_valid_T5", {31'b0, aer_valid_o}, 32'd1);
        check("t1_data", aer_data_o, expWord(8'h05));
        aer_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #2 aer_ready_i = 1'b0;
        popLog.delete();

        // Fill the queue with the router stalled, then drain.
        for (int i = 1; i <= 4; i++) fireOne(8'(i), t);
        fire_valid_i = 1'b1;
        fire_nurn_i  = 8'd5;
        repeat (10) @(posedge clk_i);
        #2 check("t2_cnt_full", {29'b0, fifo_cnt_o}, 32'd4);
        check("t2_ready_full", {31'b0, fire_ready_o}, 32'd0);
        aer_ready_i = 1'b1;
        fireOne(8'd5, t);
        repeat (15) @(posedge clk_i);
        #2 check("t2_pop_count", popLog.size(), 32'd5);
        for (int i = 0; i < 5 && i < popLog.size(); i++)
          check($sformatf("t2_order%0d", i), popLog[i], expWord(8'(i + 1)));

        // Back-to-back fires with the router always ready.
        popLog.delete();
        maxCnt = 0;
        for (int k = 0; k < 6; k++) fireOne(8'(10 + k), accT[k]);
        repeat (10) @(posedge clk_i);
        #2;
        for (int k = 1; k < 6; k++)
          check($sformatf("t3_gap%0d", k), 32'(accT[k] - accT[k-1]), 32'd50);
        check("t3_maxcnt", maxCnt, 32'd1);
        check("t3_pop_count", popLog.size(), 32'd6);
        for (int k = 0; k < 6 && k < popLog.size(); k++)
          check($sformatf("t3_order%0d", k), popLog[k], expWord(8'(10 + k)));
        aer_ready_i = 1'b0;

        // Pop on the same edge as the push with two entries queued.
        fireOne(8'd20, t);
        fireOne(8'd21, t);
        repeat (4) @(posedge clk_i);
        #2 fireOne(8'd22, t);
        repeat (3) @(posedge clk_i);
        #2 aer_ready_i = 1'b1;
        check("t4_cnt_pre", {29'b0, fifo_cnt_o}, 32'd2);
        check("t4_head_pre", aer_data_o, expWord(8'd20));
        @(posedge clk_i);
        #2 aer_ready_i = 1'b0;
        check("t4_cnt_post", {29'b0, fifo_cnt_o}, 32'd2);
        check("t4_head_post", aer_data_o, expWord(8'd21));
        aer_ready_i = 1'b1;
        repeat (6) @(posedge clk_i);
        #2 aer_ready_i = 1'b0;

        // Reset while a lookup is in WAIT and two packets are queued.
        fireOne(8'd30, t);
        fireOne(8'd31, t);
        repeat (4) @(posedge clk_i);
        #2 fireOne(8'd32, t);
        @(posedge clk_i);
        #2 rst_n_i = 1'b0;
        #1 checkAllZero("t5_rst");
        repeat (2) @(posedge clk_i);
        #2 rst_n_i = 1'b1;
        repeat (10) @(posedge clk_i);
        #2 check("t5_after", {28'b0, aer_valid_o, fifo_cnt_o}, 32'd0);

        // Ticks before a lookup: stamped only when the timestamp build is enabled.
        for (int i = 0; i < 3; i++) begin
          tick_i = 1'b1;
          @(posedge clk_i);
          #2 tick_i = 1'b0;
          @(posedge clk_i);
          #2;
        end
        fireOne(8'hFF, t);
        repeat (5) @(posedge clk_i);
        #2 check("t6_valid", {31'b0, aer_valid_o}, 32'd1);
`ifdef SPIKE_TIMESTAMP_EN
        check("t6_data", aer_data_o, 32'hFFFF_FF03);
`else
        check("t6_data", aer_data_o, 32'hFFFF_FFFF);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
      end
    join
  end

endmodule
